// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash command queue: command field layout,
// FSM state encoding and the default queue depth.
package nfc_pkg;

  localparam int CMD_W     = 33;
  localparam int RW_BIT    = 32;
  localparam int FADDR_MSB = 31;
  localparam int FADDR_LSB = 14;
  localparam int MADDR_MSB = 13;
  localparam int MADDR_LSB = 7;
  localparam int LEN_MSB   = 6;
  localparam int LEN_LSB   = 0;
  localparam int CNT_W     = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STARVE = 2'd2
  } nfc_state_t;

  // A zero-length command carries no work and is rejected at the input.
  function automatic logic len_is_zero(input logic [CMD_W-1:0] c);
    return (c[LEN_MSB:LEN_LSB] == '0);
  endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Command FIFO: DEPTH-entry circular buffer; the head entry is read straight
// from storage so it is available in the same cycle it is popped.
module nfc_cmd_fifo
  import nfc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [CMD_W-1:0]         i_data,
  output logic [CMD_W-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/nfc_cmd_queue.sv
// Host-facing command queue for the NAND flash controller: buffers commands,
// hands the next one over on each done pulse and keeps completion statistics.
module nfc_cmd_queue
  import nfc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CMD_W-1:0]       in_cmd,
  input  logic                   done,
  output logic [CMD_W-1:0]       cmd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   err_len,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [CNT_W-1:0]       max_lat
);

  nfc_state_t       r_state;
  logic [CMD_W-1:0] r_cmd;
  logic             r_busy;
  logic             r_underrun;
  logic             r_err_len;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_max_lat;
  logic [CNT_W-1:0] r_lat;

  logic             w_full;
  logic             w_empty;
  logic [CMD_W-1:0] w_head;
  logic             w_accept;
  logic             w_len_zero;
  logic             w_push_ok;
  logic             w_bypass;
  logic             w_fifo_push;
  logic             w_fifo_pop;

  assign in_ready   = !w_full;
  assign w_accept   = in_valid && in_ready;
  assign w_len_zero = len_is_zero(in_cmd);
  assign w_push_ok  = w_accept && !w_len_zero;

  // With nothing queued, a command arriving alongside done skips the FIFO.
  assign w_bypass    = done && w_empty && w_push_ok;
  assign w_fifo_push = w_push_ok && !w_bypass;
  assign w_fifo_pop  = done && !w_empty;

  nfc_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_data  (in_cmd),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_BOOT;
      r_cmd      <= '0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_err_len  <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_max_lat  <= '0;
      r_lat      <= '0;
    end else begin
      if (w_accept && w_len_zero) r_err_len <= 1'b1;

      if (done) begin
        // Only a done in RUN completes a queued command; BOOT/STARVE dones
        // are the flash reset or spurious completions and are not counted.
        if (r_state == ST_RUN) begin
          if (r_cmd[RW_BIT]) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
          else               r_wr_cnt <= r_wr_cnt + CNT_W'(1);
          if (r_lat > r_max_lat) r_max_lat <= r_lat;
        end

        if (!w_empty) begin
          r_cmd   <= w_head;
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
          r_lat   <= CNT_W'(1);
        end else if (w_push_ok) begin
          r_cmd   <= in_cmd;
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
          r_lat   <= CNT_W'(1);
        end else begin
          r_underrun <= 1'b1;
          r_state    <= ST_STARVE;
          r_busy     <= 1'b0;
        end
      end else if ((r_state == ST_RUN) && (r_lat != {CNT_W{1'b1}})) begin
        r_lat <= r_lat + CNT_W'(1);
      end
    end
  end

  assign cmd      = r_cmd;
  assign busy     = r_busy;
  assign underrun = r_underrun;
  assign err_len  = r_err_len;
  assign rd_cnt   = r_rd_cnt;
  assign wr_cnt   = r_wr_cnt;
  assign max_lat  = r_max_lat;

endmodule

// File: tb/tb_nfc_cmd_queue.sv
// Directed bench for nfc_cmd_queue: a reference model with a command
// scoreboard queue predicts every output after each clock.
module tb_nfc_cmd_queue;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_cmd = '0;
  logic        done = 1'b0;
  logic [32:0] cmd;
  logic        busy;
  logic [LW-1:0] level;
  logic        underrun;
  logic        err_len;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] max_lat;

  nfc_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .done     (done),
    .cmd      (cmd),
    .busy     (busy),
    .level    (level),
    .underrun (underrun),
    .err_len  (err_len),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .max_lat  (max_lat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = BOOT, 1 = RUN, 2 = STARVE
  int          m_state;
  logic [32:0] m_q[$];
  logic [32:0] m_cmd;
  logic        m_under;
  logic        m_errlen;
  logic [15:0] m_rd;
  logic [15:0] m_wr;
  logic [15:0] m_max;
  logic [15:0] m_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_q.delete();
    m_cmd    = '0;
    m_under  = 1'b0;
    m_errlen = 1'b0;
    m_rd     = '0;
    m_wr     = '0;
    m_max    = '0;
    m_lat    = '0;
  endtask

  task automatic model_step(input logic vld, input logic [32:0] c, input logic dn);
    logic acc, ok, load;
    acc  = vld && (m_q.size() < DEPTH);
    ok   = acc && (c[6:0] != 7'd0);
    load = 1'b0;
    if (acc && c[6:0] == 7'd0) m_errlen = 1'b1;
    if (dn) begin
      if (m_state == 1) begin
        if (m_cmd[32]) m_rd = m_rd + 16'd1;
        else           m_wr = m_wr + 16'd1;
        if (m_lat > m_max) m_max = m_lat;
      end
      if (m_q.size() != 0) begin
        m_cmd = m_q.pop_front();
        if (ok) m_q.push_back(c);
        load = 1'b1;
      end else if (ok) begin
        m_cmd = c;
        load  = 1'b1;
      end else begin
        m_under = 1'b1;
        m_state = 2;
      end
      if (load) begin
        m_state = 1;
        m_lat   = 16'd1;
      end
    end else begin
      if (ok) m_q.push_back(c);
      if (m_state == 1 && m_lat != 16'hFFFF) m_lat = m_lat + 16'd1;
    end
  endtask

  task automatic check_all(input string step);
    chk({step, "/cmd"},      cmd,      m_cmd);
    chk({step, "/busy"},     busy,     (m_state == 1));
    chk({step, "/level"},    level,    m_q.size());
    chk({step, "/in_ready"}, in_ready, (m_q.size() < DEPTH));
    chk({step, "/underrun"}, underrun, m_under);
    chk({step, "/err_len"},  err_len,  m_errlen);
    chk({step, "/rd_cnt"},   rd_cnt,   m_rd);
    chk({step, "/wr_cnt"},   wr_cnt,   m_wr);
    chk({step, "/max_lat"},  max_lat,  m_max);
  endtask

  task automatic cycle(input logic vld, input logic [32:0] c, input logic dn);
    in_valid = vld;
    in_cmd   = c;
    done     = dn;
    model_step(vld, c, dn);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_cmd   = '0;
    done     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  logic [15:0] sv_rd, sv_wr;
  logic [32:0] sv_cmd;

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1 check_all("reset_async");
    @(posedge clk);
    #1 check_all("reset_held");
    @(negedge clk);
    rst = 1'b1;

    // Push during BOOT, then the flash-reset done loads it
    cycle(1'b1, 33'h1_0000_0081, 1'b0);
    check_all("boot_push");
    cycle(1'b0, '0, 1'b1);
    check_all("boot_done");
    chk("boot_done/cmd_const", cmd, 33'h1_0000_0081);

    // Fill the queue while running
    cycle(1'b1, 33'h1_0001_0182, 1'b0);
    cycle(1'b1, 33'h0_0002_0203, 1'b0);
    cycle(1'b1, 33'h1_0003_0284, 1'b0);
    cycle(1'b1, 33'h0_0004_0305, 1'b0);
    check_all("full");
    chk("full/level_const", level, 4);
    cycle(1'b1, 33'h1_0005_0386, 1'b0);
    check_all("full_reject");
    cycle(1'b0, '0, 1'b1);
    check_all("full_pop");
    chk("full_pop/in_ready_const", in_ready, 1'b1);

    // Drain remaining entries
    cycle(1'b0, '0, 1'b1);
    check_all("drain1");
    cycle(1'b0, '0, 1'b1);
    check_all("drain2");
    cycle(1'b0, '0, 1'b1);
    check_all("drain3");

    // Empty queue: done with a simultaneous push bypasses the FIFO
    cycle(1'b1, 33'h0_0004_0105, 1'b1);
    check_all("bypass");
    chk("bypass/cmd_const", cmd, 33'h0_0004_0105);

    // Empty queue: done with no push starves
    sv_cmd = cmd;
    cycle(1'b0, '0, 1'b1);
    check_all("starve");
    chk("starve/cmd_held", cmd, sv_cmd);
    sv_rd = m_rd;
    sv_wr = m_wr;
    cycle(1'b0, '0, 1'b1);
    check_all("starve_done");
    chk("starve_done/rd_same", rd_cnt, sv_rd);
    chk("starve_done/wr_same", wr_cnt, sv_wr);

    // Zero-length command is dropped
    cycle(1'b1, 33'h1_0000_0100, 1'b0);
    check_all("len_zero");

    // One read lasting 37 cycles, then one write lasting 12
    cycle(1'b1, 33'h1_0010_2003, 1'b0);
    cycle(1'b1, 33'h0_0020_3004, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_all("rd_load");
    sv_rd = m_rd;
    idle(36);
    cycle(1'b0, '0, 1'b1);
    check_all("rd_done");
    chk("rd_done/max_lat_37", max_lat, 16'd37);
    chk("rd_done/rd_inc", rd_cnt, sv_rd + 16'd1);
    sv_wr = m_wr;
    idle(11);
    cycle(1'b0, '0, 1'b1);
    check_all("wr_done");
    chk("wr_done/wr_inc", wr_cnt, sv_wr + 16'd1);
    chk("wr_done/max_lat_kept", max_lat, 16'd37);

    // Run with three queued entries, then reset asynchronously
    cycle(1'b1, 33'h1_0030_0407, 1'b1);
    cycle(1'b1, 33'h0_0031_0488, 1'b0);
    cycle(1'b1, 33'h1_0032_0509, 1'b0);
    cycle(1'b1, 33'h0_0033_058A, 1'b0);
    check_all("pre_reset");
    #3 rst = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    @(posedge clk);
    #1 check_all("mid_reset_held");
    @(negedge clk);
    rst = 1'b1;

    // Operation resumes after reset
    cycle(1'b1, 33'h0_0040_060B, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_all("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
